// File: rtl/otter_pkg.sv
// otter_pkg: control-unit state encoding and RV32I opcode constants shared by the CU FSM and the decoder.
package otter_pkg;

    typedef enum logic [2:0] {INIT, FETCH, EXEC, WRBACK, INTR} state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    function automatic logic is_legal_op(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_IMM,
                          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYS};
    endfunction

endpackage

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle fetch/execute/writeback/interrupt sequencer for the OTTER core.
// Optional CU_FSM_ILLEGAL_TRAP_EN traps unrecognised opcodes into INTR via illegal_instr.
module otter_cu_fsm
    import otter_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       intr,
    input  logic       csr_mie,
    output logic       PC_WRITE,
    output logic       regWrite,
    output logic       memWE2,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       reset,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       illegal_instr
);

    state_t state, next_state;
    logic   int_req, is_load, is_sys, csr_op, wr_op, illegal;

    assign int_req = intr & csr_mie;
    assign is_load = opcode == OP_LOAD;
    assign is_sys  = opcode == OP_SYS;
    assign csr_op  = funct3 inside {3'b001, 3'b010, 3'b011};
    assign wr_op   = opcode inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

`ifdef CU_FSM_ILLEGAL_TRAP_EN
    assign illegal = !is_legal_op(opcode) || (is_sys && funct3[2]);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= INIT;
        else     state <= next_state;

    // Loads always finish WRBACK before an interrupt can be taken.
    always_comb begin
        next_state = INIT;
        case (state)
            INIT:    next_state = FETCH;
            FETCH:   next_state = EXEC;
            EXEC:    next_state = is_load ? WRBACK : (illegal || int_req) ? INTR : FETCH;
            WRBACK:  next_state = int_req ? INTR : FETCH;
            INTR:    next_state = FETCH;
            default: next_state = INIT;
        endcase
    end

    always_comb begin
        PC_WRITE      = 1'b0;
        regWrite      = 1'b0;
        memWE2        = 1'b0;
        memRDEN1      = 1'b0;
        memRDEN2      = 1'b0;
        reset         = 1'b0;
        csr_WE        = 1'b0;
        int_taken     = 1'b0;
        mret_exec     = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            INIT:  reset = 1'b1;
            FETCH: memRDEN1 = 1'b1;
            EXEC: begin
                memRDEN2      = is_load;
                PC_WRITE      = !is_load && !illegal;
                memWE2        = opcode == OP_STORE;
                regWrite      = wr_op || (is_sys && csr_op);
                csr_WE        = is_sys && csr_op;
                mret_exec     = is_sys && funct3 == 3'b000;
                illegal_instr = illegal;
            end
            WRBACK: begin
                regWrite = 1'b1;
                PC_WRITE = 1'b1;
            end
            INTR: begin
                int_taken = 1'b1;
                PC_WRITE  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
